// File: rtl/es8psk_tx_if.sv
// ES-8PSK transmitter bus: payload/start in, I/Q burst and status out.
interface es8psk_tx_if;
    logic [203:0]       data_8psk_tx;
    logic               ena_data_tx;
    logic signed [15:0] tx_i;
    logic signed [15:0] tx_q;
    logic               tx_valid;
    logic               busy;
    logic               done;

    modport master (
        output data_8psk_tx, ena_data_tx,
        input  tx_i, tx_q, tx_valid, busy, done
    );

    modport slave (
        input  data_8psk_tx, ena_data_tx,
        output tx_i, tx_q, tx_valid, busy, done
    );
endinterface

// File: rtl/es8psk_tx.sv
// ES-8PSK burst transmitter: preamble + 68 differential Gray 8PSK symbols,
// rectangular I/Q samples held SPS clocks each.
module es8psk_tx #(
    parameter int          SPS      = 4,
    parameter int          PRE_LEN  = 16,
    parameter logic [47:0] PREAMBLE = 48'hC5A3E96F0D2B
) (
    input  logic         clk,
    input  logic         reset_b,
    es8psk_tx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    localparam logic [3:0] SMP_LAST = 4'(SPS - 1);
    localparam logic [6:0] PRE_LAST = 7'(PRE_LEN - 1);
    localparam logic [6:0] DAT_LAST = 7'd67;

    localparam logic signed [15:0] PA = 16'sd23170;
    localparam logic signed [15:0] NA = -16'sd23170;
    localparam logic signed [15:0] PB = 16'sd16384;
    localparam logic signed [15:0] NB = -16'sd16384;
    localparam logic signed [15:0] ZR = 16'sd0;

    state_t state, state_n;
    logic [2:0]   ph, ph_n, ph_b, s;
    logic [47:0]  pre_sr, pre_sr_n;
    logic [203:0] dat_sr, dat_sr_n;
    logic [3:0]   smp, smp_n;
    logic [6:0]   sym, sym_n;
    logic         emit;

    logic signed [15:0] i_r, q_r, i_n, q_n;
    logic valid_r, busy_r, done_r;
    logic valid_n, busy_n, done_n;

    // Gray symbol to phase increment (Gray-to-binary)
    function automatic logic [2:0] gray_inc(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [31:0] point(input logic [2:0] k);
        logic [31:0] r;
        unique case (k)
            3'd0: r = {PA, ZR};
            3'd1: r = {PB, PB};
            3'd2: r = {ZR, PA};
            3'd3: r = {NB, PB};
            3'd4: r = {NA, ZR};
            3'd5: r = {NB, NB};
            3'd6: r = {ZR, NA};
            default: r = {PB, NB};
        endcase
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        ph_b     = ph;
        ph_n     = ph;
        pre_sr_n = pre_sr;
        dat_sr_n = dat_sr;
        smp_n    = smp;
        sym_n    = sym;
        s        = 3'd0;
        emit     = 1'b0;
        i_n      = i_r;
        q_n      = q_r;
        valid_n  = valid_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                i_n     = '0;
                q_n     = '0;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (bus.ena_data_tx) begin
                    state_n  = PRE;
                    ph_b     = 3'd0;
                    s        = PREAMBLE[47:45];
                    emit     = 1'b1;
                    pre_sr_n = PREAMBLE << 3;
                    dat_sr_n = bus.data_8psk_tx;
                    smp_n    = '0;
                    sym_n    = '0;
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            PRE: begin
                if (smp != SMP_LAST) begin
                    smp_n = smp + 4'd1;
                end else begin
                    smp_n = '0;
                    emit  = 1'b1;
                    if (sym == PRE_LAST) begin
                        state_n  = DATA;
                        sym_n    = '0;
                        s        = dat_sr[203:201];
                        dat_sr_n = dat_sr << 3;
                    end else begin
                        sym_n    = sym + 7'd1;
                        s        = pre_sr[47:45];
                        pre_sr_n = pre_sr << 3;
                    end
                end
            end
            DATA: begin
                if (smp != SMP_LAST) begin
                    smp_n = smp + 4'd1;
                end else begin
                    smp_n = '0;
                    if (sym == DAT_LAST) begin
                        state_n = IDLE;
                        sym_n   = '0;
                        i_n     = '0;
                        q_n     = '0;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        sym_n    = sym + 7'd1;
                        s        = dat_sr[203:201];
                        dat_sr_n = dat_sr << 3;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (emit) begin
            ph_n       = ph_b + gray_inc(s);
            {i_n, q_n} = point(ph_n);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= IDLE;
            ph      <= '0;
            pre_sr  <= '0;
            dat_sr  <= '0;
            smp     <= '0;
            sym     <= '0;
            i_r     <= '0;
            q_r     <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            ph      <= ph_n;
            pre_sr  <= pre_sr_n;
            dat_sr  <= dat_sr_n;
            smp     <= smp_n;
            sym     <= sym_n;
            i_r     <= i_n;
            q_r     <= q_n;
            valid_r <= valid_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    assign bus.tx_i     = i_r;
    assign bus.tx_q     = q_r;
    assign bus.tx_valid = valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_es8psk_tx.sv
// Directed bench for es8psk_tx: reset abort, phase walk, wrap, bit order,
// start-during-busy and back-to-back bursts.
module tb_es8psk_tx;
    localparam int N = 336;

    localparam logic [31:0] P0 = {16'd23170, 16'd0};
    localparam logic [31:0] P1 = {16'd16384, 16'd16384};
    localparam logic [31:0] P2 = {16'd0, 16'd23170};
    localparam logic [31:0] P3 = {16'hC000, 16'd16384};
    localparam logic [31:0] P4 = {16'hA57E, 16'd0};
    localparam logic [31:0] P5 = {16'hC000, 16'hC000};
    localparam logic [31:0] P6 = {16'd0, 16'hA57E};
    localparam logic [31:0] P7 = {16'd16384, 16'hC000};

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] cap [N];

    es8psk_tx_if bus ();

    es8psk_tx #(.SPS(4), .PRE_LEN(16)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [34:0] got,
                         input logic [34:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ginv(input logic [2:0] g);
        case (g)
            3'b000: return 0;
            3'b001: return 1;
            3'b011: return 2;
            3'b010: return 3;
            3'b110: return 4;
            3'b111: return 5;
            3'b101: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] pt(input int k);
        case (k)
            0: return P0;
            1: return P1;
            2: return P2;
            3: return P3;
            4: return P4;
            5: return P5;
            6: return P6;
            default: return P7;
        endcase
    endfunction

    function automatic logic [34:0] outs();
        return {bus.tx_valid, bus.busy, bus.done, bus.tx_i, bus.tx_q};
    endfunction

    // Assumes the accepting edge has passed; ends 1 cycle after done.
    task automatic run_burst(input logic [203:0] pl, input bit inj,
                             input bit btb, input logic [203:0] nxt);
        logic [47:0] pre;
        logic [2:0] b;
        logic [31:0] e [84];
        int p;
        pre = 48'hC5A3E96F0D2B;
        p = 0;
        for (int n = 0; n < 84; n++) begin
            if (n < 16) b = pre[47 - 3*n -: 3];
            else        b = pl[203 - 3*(n-16) -: 3];
            p = (p + ginv(b)) % 8;
            e[n] = pt(p);
        end
        for (int k = 0; k < N; k++) begin
            cap[k] = {bus.tx_i, bus.tx_q};
            check($sformatf("smp%0d", k), outs(), {3'b110, e[k/4]});
            bus.ena_data_tx = inj && (k == 50);
            @(posedge clk); #1;
        end
        check("done", outs(), {3'b001, 32'd0});
        bus.ena_data_tx = btb;
        bus.data_8psk_tx = nxt;
        @(posedge clk); #1;
        bus.ena_data_tx = 1'b0;
        if (!btb) check("idle", outs(), 35'd0);
    endtask

    task automatic start(input logic [203:0] pl);
        bus.data_8psk_tx = pl;
        bus.ena_data_tx = 1'b1;
        @(posedge clk); #1;
        bus.ena_data_tx = 1'b0;
        bus.data_8psk_tx = '0;
    endtask

    initial begin
        logic [203:0] pl;
        int dones;
        bus.ena_data_tx = 1'b0;
        bus.data_8psk_tx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst", outs(), 35'd0);
        reset_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 204; i++) pl[i] = 1'($urandom_range(0, 1));
        start(pl);
        repeat (100) @(posedge clk);
        #1;
        check("mid_valid", {34'd0, bus.tx_valid}, 35'd1);
        reset_b = 1'b0;
        #1;
        check("abort", outs(), 35'd0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        dones = 0;
        for (int k = 0; k < 340; k++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        check("nodone", 35'(dones), 35'd0);
        start(pl);
        run_burst(pl, 1'b0, 1'b0, '0);

        start('0);
        run_burst('0, 1'b0, 1'b0, '0);
        check("z_pre0", {3'b0, cap[0]}, {3'b0, P4});
        check("z_pre15", {3'b0, cap[63]}, {3'b0, P2});
        check("z_dat0", {3'b0, cap[64]}, {3'b0, P2});
        check("z_last", {3'b0, cap[335]}, {3'b0, P2});

        pl = {68{3'b001}};
        start(pl);
        run_burst(pl, 1'b0, 1'b0, '0);
        check("w_d0", {3'b0, cap[64]}, {3'b0, P3});
        check("w_d0h", {3'b0, cap[67]}, {3'b0, P3});
        check("w_d1", {3'b0, cap[68]}, {3'b0, P4});
        check("w_d5", {3'b0, cap[84]}, {3'b0, P0});
        check("w_d6", {3'b0, cap[88]}, {3'b0, P1});
        check("w_d8", {3'b0, cap[96]}, {3'b0, P3});

        pl = '0;
        pl[203:201] = 3'b011;
        start(pl);
        run_burst(pl, 1'b0, 1'b0, '0);
        check("b_pre", {3'b0, cap[63]}, {3'b0, P2});
        check("b_d0", {3'b0, cap[64]}, {3'b0, P4});
        check("b_last", {3'b0, cap[335]}, {3'b0, P4});

        for (int i = 0; i < 204; i++) pl[i] = 1'($urandom_range(0, 1));
        start(pl);
        run_burst(pl, 1'b1, 1'b1, {68{3'b001}});
        run_burst({68{3'b001}}, 1'b0, 1'b0, '0);
        check("btb_d0", {3'b0, cap[64]}, {3'b0, P3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
